// File: rtl/ir_packet_scheduler_pkg.sv
// Shared encodings for the IR packet scheduler: FSM states, register offsets
// and control-register bit positions.
package ir_packet_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StHold = 2'd2,
        StWait = 2'd3
    } state_e;

    localparam logic [7:0] RegCmdOffset  = 8'd0;
    localparam logic [7:0] RegCtrlOffset = 8'd1;

    localparam int unsigned CtrlEnableBit  = 0;
    localparam int unsigned CtrlOneshotBit = 1;
    localparam int unsigned CtrlCarSelLsb  = 2;

    localparam int unsigned PeriodCntWidth = 23;
    localparam int unsigned HoldCntWidth   = 20;

endpackage

// File: rtl/ir_packet_scheduler.sv
// Schedules IR packet transmissions: bus-written command/car shadows are latched
// into the active outputs on each send, either periodically or as one-shots.
module ir_packet_scheduler
    import ir_packet_scheduler_pkg::*;
#(
    parameter logic [7:0]  BaseAddr     = 8'h90,
    parameter int unsigned PacketPeriod = 5_000_000,
    parameter int unsigned HoldCycles   = 700_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       SEND_PACKET,
    output logic [3:0] COMMAND,
    output logic [1:0] CAR_SEL,
    output logic       BUSY
);

    localparam logic [7:0] CmdAddr  = BaseAddr + RegCmdOffset;
    localparam logic [7:0] CtrlAddr = BaseAddr + RegCtrlOffset;
    localparam logic [PeriodCntWidth-1:0] PeriodLast = PeriodCntWidth'(PacketPeriod - 1);
    localparam logic [HoldCntWidth-1:0]   HoldLast   = HoldCntWidth'(HoldCycles - 1);

    state_e                    state_q, state_d;
    logic [3:0]                cmd_shadow_q, cmd_shadow_d;
    logic [1:0]                car_shadow_q, car_shadow_d;
    logic                      enable_q, enable_d;
    logic                      oneshot_q, oneshot_d;
    logic [3:0]                command_q, command_d;
    logic [1:0]                car_sel_q, car_sel_d;
    logic [PeriodCntWidth-1:0] period_cnt_q, period_cnt_d;
    logic [HoldCntWidth-1:0]   hold_cnt_q, hold_cnt_d;

    logic cmd_wr, ctrl_wr, enter_send;

    logic unused_bus_data;
    assign unused_bus_data = ^BUS_DATA[7:4];

    assign cmd_wr  = BUS_WE && (BUS_ADDR == CmdAddr);
    assign ctrl_wr = BUS_WE && (BUS_ADDR == CtrlAddr);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (enable_q || oneshot_q) state_d = StSend;
            StSend: state_d = StHold;
            StHold: if (hold_cnt_q == HoldLast) state_d = enable_q ? StWait : StIdle;
            // A pending one-shot waits for the regular slot rather than jumping ahead.
            StWait: begin
                if (!enable_q) begin
                    state_d = StIdle;
                end else if (period_cnt_q == PeriodLast) begin
                    state_d = StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign enter_send = (state_d == StSend);

    always_comb begin
        cmd_shadow_d = cmd_shadow_q;
        car_shadow_d = car_shadow_q;
        enable_d     = enable_q;
        oneshot_d    = oneshot_q;
        command_d    = command_q;
        car_sel_d    = car_sel_q;
        period_cnt_d = period_cnt_q + 1'b1;
        hold_cnt_d   = hold_cnt_q;

        if (cmd_wr) begin
            cmd_shadow_d = BUS_DATA[3:0];
        end
        if (ctrl_wr) begin
            enable_d     = BUS_DATA[CtrlEnableBit];
            car_shadow_d = BUS_DATA[CtrlCarSelLsb +: 2];
        end

        // Outputs take the registered shadows, so a same-edge write lands in the next packet.
        if (enter_send) begin
            command_d    = cmd_shadow_q;
            car_sel_d    = car_shadow_q;
            oneshot_d    = 1'b0;
            period_cnt_d = '0;
            hold_cnt_d   = '0;
        end else begin
            if (state_d == StIdle) period_cnt_d = '0;
            if (state_q == StHold) hold_cnt_d = hold_cnt_q + 1'b1;
        end

        if (ctrl_wr && BUS_DATA[CtrlOneshotBit]) begin
            oneshot_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            cmd_shadow_q <= '0;
            car_shadow_q <= '0;
            enable_q     <= 1'b0;
            oneshot_q    <= 1'b0;
            command_q    <= '0;
            car_sel_q    <= '0;
            period_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cmd_shadow_q <= cmd_shadow_d;
            car_shadow_q <= car_shadow_d;
            enable_q     <= enable_d;
            oneshot_q    <= oneshot_d;
            command_q    <= command_d;
            car_sel_q    <= car_sel_d;
            period_cnt_q <= period_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign SEND_PACKET = (state_q == StSend);
    assign BUSY        = (state_q == StSend) || (state_q == StHold);
    assign COMMAND     = command_q;
    assign CAR_SEL     = car_sel_q;

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Scoreboard bench for ir_packet_scheduler: expected pulses are queued by the
// stimulus and checked by an independent monitor whenever SEND_PACKET fires.
module tb_ir_packet_scheduler;

    localparam logic [7:0] Base  = 8'h90;
    localparam logic [7:0] CtrlA = 8'h91;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] BUS_ADDR = 8'h00;
    logic [7:0] BUS_DATA = 8'h00;
    logic       BUS_WE = 1'b0;
    logic       SEND_PACKET;
    logic [3:0] COMMAND;
    logic [1:0] CAR_SEL;
    logic       BUSY;

    ir_packet_scheduler #(
        .BaseAddr    (Base),
        .PacketPeriod(100),
        .HoldCycles  (40)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BUS_ADDR   (BUS_ADDR),
        .BUS_DATA   (BUS_DATA),
        .BUS_WE     (BUS_WE),
        .SEND_PACKET(SEND_PACKET),
        .COMMAND    (COMMAND),
        .CAR_SEL    (CAR_SEL),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // cyc = number of rising edges seen so far
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [1:0] car;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] cmd, input logic [1:0] car);
        exp_t e;
        e.cyc = c;
        e.cmd = cmd;
        e.car = car;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic sample_at(input int n);
        wait_until(n);
        @(negedge CLK);
    endtask

    // Write is captured by rising edge number k.
    task automatic bus_write_at(input int k, input logic [7:0] addr, input logic [7:0] data);
        wait_until(k - 1);
        BUS_ADDR = addr;
        BUS_DATA = data;
        BUS_WE   = 1'b1;
        @(posedge CLK);
        #1;
        BUS_WE   = 1'b0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (mon_en && SEND_PACKET === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d required none", cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_command", int'(COMMAND), int'(e.cmd));
                check("pulse_car_sel", int'(CAR_SEL), int'(e.car));
                check("pulse_busy", int'(BUSY), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_n;

        // Control write while reset is held must be discarded.
        wait_until(2);
        bus_write_at(3, CtrlA, 8'h01);
        wait_until(4);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_send_packet", int'(SEND_PACKET), 0);
        check("rst_command", int'(COMMAND), 0);
        check("rst_car_sel", int'(CAR_SEL), 0);
        check("rst_busy", int'(BUSY), 0);
        mon_en = 1'b1;
        sample_at(10);
        check("rst_beats_write", int'(BUSY), 0);

        // Periodic mode, command change during HOLD, write on the send edge.
        bus_write_at(20, Base, 8'h05);
        bus_write_at(30, CtrlA, 8'h01);
        push(31, 4'h5, 2'b00);
        push(131, 4'hA, 2'b00);
        push(231, 4'h3, 2'b00);
        bus_write_at(40, Base, 8'h0A);
        sample_at(80);
        check("cmd_frozen_wait", int'(COMMAND), 5);
        bus_write_at(131, Base, 8'h03);
        sample_at(150);
        check("cmd_after_send", int'(COMMAND), 10);
        // Disable at HOLD cycle 10 of the packet sent at 231 (HOLD spans 232..271).
        bus_write_at(242, CtrlA, 8'h00);
        sample_at(271);
        check("hold_not_shortened", int'(BUSY), 1);
        sample_at(272);
        check("idle_after_hold", int'(BUSY), 0);
        sample_at(340);
        check("periodic_drained", sb.size(), 0);

        // One-shot with ENABLE=0: single pulse, BUSY for 41 cycles.
        bus_write_at(400, CtrlA, 8'h0E);
        push(401, 4'h3, 2'b11);
        busy_n = 0;
        repeat (61) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
        end
        check("oneshot_busy_len", busy_n, 41);
        sample_at(520);
        check("oneshot_drained", sb.size(), 0);
        check("oneshot_idle", int'(BUSY), 0);

        // One-shot request during HOLD is served after HOLD via IDLE.
        bus_write_at(600, CtrlA, 8'h06);
        push(601, 4'h3, 2'b01);
        bus_write_at(620, CtrlA, 8'h02);
        push(643, 4'h3, 2'b00);
        sample_at(642);
        check("pend_gap_busy", int'(BUSY), 0);
        check("pend_gap_pulse", int'(SEND_PACKET), 0);
        sample_at(700);
        check("pend_drained", sb.size(), 0);

        // Reset at HOLD cycle 20 (HOLD spans 802..841).
        bus_write_at(800, CtrlA, 8'h01);
        push(801, 4'h3, 2'b00);
        wait_until(821);
        RST = 1'b1;
        wait_until(822);
        RST = 1'b0;
        @(negedge CLK);
        check("midhold_rst_send_packet", int'(SEND_PACKET), 0);
        check("midhold_rst_command", int'(COMMAND), 0);
        check("midhold_rst_car_sel", int'(CAR_SEL), 0);
        check("midhold_rst_busy", int'(BUSY), 0);
        sample_at(1000);
        check("post_rst_silent", sb.size(), 0);
        check("post_rst_busy", int'(BUSY), 0);

        // Re-enable after reset: shadows were cleared.
        bus_write_at(1010, CtrlA, 8'h01);
        push(1011, 4'h0, 2'b00);
        bus_write_at(1020, CtrlA, 8'h00);
        sample_at(1150);
        check("reenable_drained", sb.size(), 0);
        check("final_busy", int'(BUSY), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
